fetch_mem_wb_stages: RTL and testbench
======================================

Name: fetch_mem_wb_stages

Overview:
- Bundles three MIPS datapath stages behind one clock: instruction fetch, data-memory access, and register write-back.
- Each stage is started by a one-cycle enable token and returns a one-cycle done token. A sequencer chains stages by wiring done to the next stage's enable.
- Owns the instruction memory, data memory and register file.

Parameters:
- DATA_W, 32, data/instruction width in bits.
- IMEM_AW, 4, instruction memory address width (16 words).
- DMEM_AW, 8, data memory address width (256 words).
- RF_AW, 6, register file address width (64 registers).

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- start  input  1  reset, synchronous, active-high.
- imem_we  input  1  instruction memory load strobe.
- imem_waddr  input  IMEM_AW  load address.
- imem_wdata  input  DATA_W  load data.
- pc  input  IMEM_AW  fetch address.
- fetch_en  input  1  fetch stage token in.
- cur_instr  output  DATA_W  fetched instruction.
- fetch_done  output  1  fetch token out.
- mem_en  input  1  memory stage token in.
- mem_write  input  1  data memory write control.
- mem_read  input  1  data memory read control.
- mem_addr  input  DMEM_AW  data memory word address.
- mem_wdata  input  DATA_W  store data.
- mem_rdata  output  DATA_W  load result.
- mem_done  output  1  memory token out.
- wb_en  input  1  write-back token in.
- wb_ctrl  input  1  register write control.
- wb_addr  input  RF_AW  destination register.
- wb_data  input  DATA_W  write-back value.
- wb_done  output  1  write-back token out.
- rf_raddr  input  RF_AW  debug/operand read address.
- rf_rdata  output  DATA_W  combinational register read.

Behaviour:
- Reset (start=1 at edge):
  - cur_instr, mem_rdata, fetch_done, mem_done and wb_done all go to 0.
  - All registers cleared to 0.
  - Instruction and data memory contents are retained.
  - Reset overrides any enable sampled in the same cycle; no memory or register write occurs.
- Instruction load: imem_we=1 at an edge writes imem[imem_waddr]=imem_wdata. Load is independent of the stage enables.
- Fetch: with fetch_en=1 at edge N, cur_instr=imem[pc] is valid after N and fetch_done=1 for exactly one cycle.
  - If the same address is loaded at edge N, the fetch returns the old word.
  - cur_instr holds its value while fetch_en=0.
- Memory stage: with mem_en=1 at edge N, mem_done pulses for one cycle after N.
  - mem_write=1: dmem[mem_addr]=mem_wdata.
  - mem_read=1: mem_rdata=dmem[mem_addr], valid after N.
  - Both set: write occurs; mem_rdata returns the pre-write contents (read-before-write).
  - Neither set: no access, mem_rdata holds, mem_done still pulses.
  - Controls are ignored while mem_en=0.
- Write-back: with wb_en=1 at edge N, wb_done pulses for one cycle after N.
  - If wb_ctrl=1 and wb_addr!=0, rf[wb_addr]=wb_data.
  - Register 0 always reads 0; writes to it are discarded.
- Register read: rf_rdata=rf[rf_raddr] combinationally.
- Concurrency: all three stages may be enabled in the same cycle and operate independently.
- Back-to-back enables produce back-to-back done pulses; there are no stalls. A continuously high enable gives a done pulse every cycle.
- Widths: all addresses index directly with no wrap logic needed; the full address range is valid.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: if wb_en and wb_ctrl are 1, wb_addr==rf_raddr and wb_addr!=0 in the same cycle, rf_rdata returns wb_data (write-through forwarding).
- Undefined: rf_rdata shows the old contents until after the edge.

Decomposition:
- Package mips_stage_pkg: DATA_W, IMEM_AW, DMEM_AW and RF_AW defaults, plus the constant REG_ZERO=0.
- One sub-module, mips_reg_file: 64x32 register file with synchronous write, combinational read, hardwired zero register, and the bypass option.
- Memories stay inline.

Test Plan:
- Reset with start=1 while fetch_en=mem_en=wb_en=1 -> all outputs 0, no done pulses, rf_rdata(5)=0.
- Load imem[3]=0x8C220004, pc=3, fetch_en pulse -> next cycle cur_instr=0x8C220004, fetch_done high for exactly 1 cycle.
- mem_en+mem_write, addr 0x10, data 0xDEADBEEF; then mem_en+mem_read addr 0x10 -> mem_rdata=0xDEADBEEF. Repeat with read+write of 0x12345678 -> mem_rdata=0xDEADBEEF and memory then holds 0x12345678.
- wb_en+wb_ctrl, addr 7, data 0xA5A5A5A5 -> rf_rdata(7)=0xA5A5A5A5 after the edge. Same to addr 0 -> rf_rdata(0)=0. wb_ctrl=0 -> unchanged but wb_done pulses.
- All three enables held high 4 cycles with varying addresses -> four consecutive done pulses per stage, every access correct.
- With RF_BYPASS_EN, write addr 9 value 0x55 while rf_raddr=9 -> rf_rdata=0x55 in the same cycle. Without the macro -> old value (0 after reset).

Source files
------------

// File: rtl/mips_stage_pkg.sv
// mips_stage_pkg
// Shared widths for the fetch / memory / write-back stage bundle.
//   DATA_W   : data and instruction width
//   IMEM_AW  : instruction memory word address width (16 words)
//   DMEM_AW  : data memory word address width (256 words)
//   RF_AW    : register file address width (64 registers)
//   REG_ZERO : address of the hardwired-zero register
package mips_stage_pkg;
    localparam int DATA_W  = 32;
    localparam int IMEM_AW = 4;
    localparam int DMEM_AW = 8;
    localparam int RF_AW   = 6;

    localparam logic [RF_AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/fetch_mem_wb_stages_if.sv
// fetch_mem_wb_stages_if
// Groups every stage-level signal of fetch_mem_wb_stages into one bundle.
//   master : sequencer side (drives tokens, controls, addresses, data)
//   slave  : stage side (returns fetched word, load data, done tokens, rf read)
interface fetch_mem_wb_stages_if #(
    parameter int DATA_W  = mips_stage_pkg::DATA_W,
    parameter int IMEM_AW = mips_stage_pkg::IMEM_AW,
    parameter int DMEM_AW = mips_stage_pkg::DMEM_AW,
    parameter int RF_AW   = mips_stage_pkg::RF_AW
);
    // Instruction memory load port
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [DATA_W-1:0]  imem_wdata;
    // Fetch stage
    logic [IMEM_AW-1:0] pc;
    logic               fetch_en;
    logic [DATA_W-1:0]  cur_instr;
    logic               fetch_done;
    // Memory stage
    logic               mem_en;
    logic               mem_write;
    logic               mem_read;
    logic [DMEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_done;
    // Write-back stage
    logic               wb_en;
    logic               wb_ctrl;
    logic [RF_AW-1:0]   wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               wb_done;
    // Register read port
    logic [RF_AW-1:0]   rf_raddr;
    logic [DATA_W-1:0]  rf_rdata;

    modport master (
        output imem_we, imem_waddr, imem_wdata,
        output pc, fetch_en,
        input  cur_instr, fetch_done,
        output mem_en, mem_write, mem_read, mem_addr, mem_wdata,
        input  mem_rdata, mem_done,
        output wb_en, wb_ctrl, wb_addr, wb_data,
        input  wb_done,
        output rf_raddr,
        input  rf_rdata
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata,
        input  pc, fetch_en,
        output cur_instr, fetch_done,
        input  mem_en, mem_write, mem_read, mem_addr, mem_wdata,
        output mem_rdata, mem_done,
        input  wb_en, wb_ctrl, wb_addr, wb_data,
        output wb_done,
        input  rf_raddr,
        output rf_rdata
    );
endinterface

// File: rtl/mips_reg_file.sv
// mips_reg_file
// 2^RF_AW x DATA_W register file: one synchronous write port, one
// combinational read port, register 0 hardwired to zero. srst clears all
// registers. Build option RF_BYPASS_EN forwards the in-flight write data to
// the read port when the addresses match (write-through).
//   clk, srst : clock, synchronous active-high reset
//   we_i      : write enable (ignored while srst is high)
//   waddr_i   : write address,  wdata_i : write data
//   raddr_i   : read address,   rdata_o : read data
module mips_reg_file
    import mips_stage_pkg::*;
#(
    parameter int DATA_W = mips_stage_pkg::DATA_W,
    parameter int RF_AW  = mips_stage_pkg::RF_AW
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we_i,
    input  logic [RF_AW-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RF_AW-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int NREG = 1 << RF_AW;

    logic [DATA_W-1:0] rf_q [NREG];

    // Each register is its own flop so the whole file can be cleared in one
    // cycle; register 0 is a constant and never stores anything.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign rf_q[gi] = '0;
        end else begin : g_flop
            logic [DATA_W-1:0] reg_q;
            always_ff @(posedge clk) begin
                if (srst) begin
                    reg_q <= '0;
                end else if (we_i && (waddr_i == RF_AW'(gi))) begin
                    reg_q <= wdata_i;
                end
            end
            assign rf_q[gi] = reg_q;
        end
    end

    always_comb begin
        rdata_o = rf_q[raddr_i];
`ifdef RF_BYPASS_EN
        // Forward only a write that will really land at the next edge.
        if (!srst && we_i && (waddr_i == raddr_i) && (waddr_i != REG_ZERO)) begin
            rdata_o = wdata_i;
        end
`endif
    end
endmodule

// File: rtl/fetch_mem_wb_stages.sv
// fetch_mem_wb_stages
// Instruction fetch, data-memory access and register write-back stages on
// one clock. Each stage takes a one-cycle enable token and returns a
// one-cycle done token on the following cycle; stages never stall.
// Optional build macro: RF_BYPASS_EN (register-file write-through forwarding).
//   clock : sole clock
//   start : synchronous active-high reset (clears outputs and registers,
//           keeps memory contents, blocks all writes in that cycle)
//   bus   : stage signals (slave side of fetch_mem_wb_stages_if)
module fetch_mem_wb_stages
    import mips_stage_pkg::*;
#(
    parameter int DATA_W  = mips_stage_pkg::DATA_W,
    parameter int IMEM_AW = mips_stage_pkg::IMEM_AW,
    parameter int DMEM_AW = mips_stage_pkg::DMEM_AW,
    parameter int RF_AW   = mips_stage_pkg::RF_AW
) (
    input  logic                  clock,
    input  logic                  start,
    fetch_mem_wb_stages_if.slave  bus
);
    localparam int IMEM_WORDS = 1 << IMEM_AW;
    localparam int DMEM_WORDS = 1 << DMEM_AW;

    logic [DATA_W-1:0] imem_mem [IMEM_WORDS];
    logic [DATA_W-1:0] dmem_mem [DMEM_WORDS];

    logic [DATA_W-1:0] cur_instr_q;
    logic              fetch_done_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              mem_done_q;
    logic              wb_done_q;
    logic              rf_we;

    // ---------------- instruction memory / fetch ----------------
    always_ff @(posedge clock) begin
        if (!start && bus.imem_we) begin
            imem_mem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    // Registered read: a load to the same address in the same cycle is seen
    // only by later fetches.
    always_ff @(posedge clock) begin
        if (start) begin
            cur_instr_q  <= '0;
            fetch_done_q <= 1'b0;
        end else begin
            fetch_done_q <= bus.fetch_en;
            if (bus.fetch_en) begin
                cur_instr_q <= imem_mem[bus.pc];
            end
        end
    end

    // ---------------- data memory stage ----------------
    always_ff @(posedge clock) begin
        if (!start && bus.mem_en && bus.mem_write) begin
            dmem_mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // Read and write of the same word in one cycle returns the old contents.
    always_ff @(posedge clock) begin
        if (start) begin
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
        end else begin
            mem_done_q <= bus.mem_en;
            if (bus.mem_en && bus.mem_read) begin
                mem_rdata_q <= dmem_mem[bus.mem_addr];
            end
        end
    end

    // ---------------- write-back stage ----------------
    always_ff @(posedge clock) begin
        if (start) begin
            wb_done_q <= 1'b0;
        end else begin
            wb_done_q <= bus.wb_en;
        end
    end

    assign rf_we = bus.wb_en & bus.wb_ctrl;

    mips_reg_file #(
        .DATA_W (DATA_W),
        .RF_AW  (RF_AW)
    ) u_reg_file (
        .clk     (clock),
        .srst    (start),
        .we_i    (rf_we),
        .waddr_i (bus.wb_addr),
        .wdata_i (bus.wb_data),
        .raddr_i (bus.rf_raddr),
        .rdata_o (bus.rf_rdata)
    );

    assign bus.cur_instr  = cur_instr_q;
    assign bus.fetch_done = fetch_done_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.mem_done   = mem_done_q;
    assign bus.wb_done    = wb_done_q;
endmodule

// File: tb/tb_fetch_mem_wb_stages.sv
// tb_fetch_mem_wb_stages
// Directed-vector bench for fetch_mem_wb_stages. Inputs change 1 time unit
// after a rising edge; outputs are compared at that same point.
module tb_fetch_mem_wb_stages;
    logic clock = 1'b0;
    logic start;

    fetch_mem_wb_stages_if bus ();

    fetch_mem_wb_stages dut (
        .clock (clock),
        .start (start),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-22s obs=%08h exp=%08h ok", tag, obs, exp);
        end else begin
            $display("FAIL %-22s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.imem_we   = 1'b0;
        bus.fetch_en  = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.wb_en     = 1'b0;
        bus.wb_ctrl   = 1'b0;
    endtask

    logic [31:0] pre_exp;

    initial begin
        // Reset with every enable and write control asserted.
        start          = 1'b1;
        bus.imem_we    = 1'b0;
        bus.imem_waddr = '0;
        bus.imem_wdata = '0;
        bus.pc         = '0;
        bus.fetch_en   = 1'b1;
        bus.mem_en     = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_read   = 1'b1;
        bus.mem_addr   = 8'h10;
        bus.mem_wdata  = 32'hFFFF_FFFF;
        bus.wb_en      = 1'b1;
        bus.wb_ctrl    = 1'b1;
        bus.wb_addr    = 6'd5;
        bus.wb_data    = 32'h1234_5678;
        bus.rf_raddr   = 6'd5;
        tick();
        tick();
        check_eq("rst_cur_instr", bus.cur_instr, 32'h0);
        check_eq("rst_mem_rdata", bus.mem_rdata, 32'h0);
        check_eq("rst_fetch_done", {31'd0, bus.fetch_done}, 32'h0);
        check_eq("rst_mem_done", {31'd0, bus.mem_done}, 32'h0);
        check_eq("rst_wb_done", {31'd0, bus.wb_done}, 32'h0);
        check_eq("rst_rf5", bus.rf_rdata, 32'h0);
        start = 1'b0;
        idle();
        tick();
        check_eq("rst_rf5_after", bus.rf_rdata, 32'h0);

        // Instruction load then fetch.
        bus.imem_we = 1'b1; bus.imem_waddr = 4'd3; bus.imem_wdata = 32'h8C22_0004;
        tick();
        bus.imem_we = 1'b0;
        bus.pc = 4'd3; bus.fetch_en = 1'b1;
        tick();
        bus.fetch_en = 1'b0;
        check_eq("fetch_instr", bus.cur_instr, 32'h8C22_0004);
        check_eq("fetch_done_hi", {31'd0, bus.fetch_done}, 32'h1);
        tick();
        check_eq("fetch_done_lo", {31'd0, bus.fetch_done}, 32'h0);
        check_eq("fetch_hold", bus.cur_instr, 32'h8C22_0004);

        // Load and fetch the same address in one cycle: old word returned.
        bus.imem_we = 1'b1; bus.imem_waddr = 4'd3; bus.imem_wdata = 32'h0000_0011;
        bus.fetch_en = 1'b1; bus.pc = 4'd3;
        tick();
        bus.imem_we = 1'b0;
        check_eq("fetch_same_cycle_old", bus.cur_instr, 32'h8C22_0004);
        tick();
        bus.fetch_en = 1'b0;
        check_eq("fetch_new_word", bus.cur_instr, 32'h0000_0011);

        // Top instruction address.
        bus.imem_we = 1'b1; bus.imem_waddr = 4'd15; bus.imem_wdata = 32'hCAFE_F00D;
        tick();
        bus.imem_we = 1'b0; bus.fetch_en = 1'b1; bus.pc = 4'd15;
        tick();
        bus.fetch_en = 1'b0;
        check_eq("fetch_pc15", bus.cur_instr, 32'hCAFE_F00D);

        // Memory stage: write, read, read+write, read, no-op, disabled write.
        bus.mem_en = 1'b1; bus.mem_write = 1'b1; bus.mem_read = 1'b0;
        bus.mem_addr = 8'h10; bus.mem_wdata = 32'hDEAD_BEEF;
        tick();
        check_eq("mem_done_wr", {31'd0, bus.mem_done}, 32'h1);
        check_eq("mem_rdata_hold_wr", bus.mem_rdata, 32'h0);
        bus.mem_write = 1'b0; bus.mem_read = 1'b1;
        tick();
        check_eq("mem_read", bus.mem_rdata, 32'hDEAD_BEEF);
        bus.mem_write = 1'b1; bus.mem_wdata = 32'h1234_5678;
        tick();
        check_eq("mem_rbw_old", bus.mem_rdata, 32'hDEAD_BEEF);
        bus.mem_write = 1'b0;
        tick();
        check_eq("mem_rbw_new", bus.mem_rdata, 32'h1234_5678);
        bus.mem_read = 1'b0;
        tick();
        check_eq("mem_noop_done", {31'd0, bus.mem_done}, 32'h1);
        check_eq("mem_noop_hold", bus.mem_rdata, 32'h1234_5678);
        bus.mem_en = 1'b0; bus.mem_write = 1'b1; bus.mem_wdata = 32'h0;
        tick();
        check_eq("mem_dis_done", {31'd0, bus.mem_done}, 32'h0);
        bus.mem_write = 1'b0; bus.mem_en = 1'b1; bus.mem_read = 1'b1;
        tick();
        check_eq("mem_dis_nowrite", bus.mem_rdata, 32'h1234_5678);
        bus.mem_read = 1'b0; bus.mem_write = 1'b1;
        bus.mem_addr = 8'hFF; bus.mem_wdata = 32'h0BAD_F00D;
        tick();
        bus.mem_write = 1'b0; bus.mem_read = 1'b1;
        tick();
        idle();
        check_eq("mem_addr255", bus.mem_rdata, 32'h0BAD_F00D);

        // Write-back.
        bus.wb_en = 1'b1; bus.wb_ctrl = 1'b1; bus.wb_addr = 6'd7;
        bus.wb_data = 32'hA5A5_A5A5; bus.rf_raddr = 6'd7;
        tick();
        check_eq("wb_done", {31'd0, bus.wb_done}, 32'h1);
        check_eq("wb_rf7", bus.rf_rdata, 32'hA5A5_A5A5);
        bus.wb_addr = 6'd0; bus.wb_data = 32'hFFFF_FFFF; bus.rf_raddr = 6'd0;
        tick();
        check_eq("wb_rf0", bus.rf_rdata, 32'h0);
        bus.wb_ctrl = 1'b0; bus.wb_addr = 6'd7; bus.wb_data = 32'h0; bus.rf_raddr = 6'd7;
        tick();
        check_eq("wb_noctrl_done", {31'd0, bus.wb_done}, 32'h1);
        check_eq("wb_noctrl_rf7", bus.rf_rdata, 32'hA5A5_A5A5);
        bus.wb_ctrl = 1'b1; bus.wb_addr = 6'd63; bus.wb_data = 32'h6363_6363; bus.rf_raddr = 6'd63;
        tick();
        check_eq("wb_rf63", bus.rf_rdata, 32'h6363_6363);
        idle();
        tick();
        check_eq("wb_done_lo", {31'd0, bus.wb_done}, 32'h0);

        // Same-cycle read of register being written.
        bus.rf_raddr = 6'd9;
        #1;
        check_eq("rf9_before", bus.rf_rdata, 32'h0);
        bus.wb_en = 1'b1; bus.wb_ctrl = 1'b1; bus.wb_addr = 6'd9; bus.wb_data = 32'h55;
`ifdef RF_BYPASS_EN
        pre_exp = 32'h55;
`else
        pre_exp = 32'h0;
`endif
        #1;
        check_eq("rf9_same_cycle", bus.rf_rdata, pre_exp);
        tick();
        idle();
        check_eq("rf9_after", bus.rf_rdata, 32'h55);

        // Preload imem[4..7] for the concurrent run.
        for (int i = 4; i < 8; i++) begin
            bus.imem_we = 1'b1; bus.imem_waddr = 4'(i); bus.imem_wdata = 32'h1000 + 32'(i);
            tick();
        end
        bus.imem_we = 1'b0;

        // All three stages enabled for four back-to-back cycles.
        for (int k = 0; k < 4; k++) begin
            bus.fetch_en = 1'b1; bus.pc = 4'(4 + k);
            bus.mem_en = 1'b1; bus.mem_write = 1'b1; bus.mem_read = 1'b0;
            bus.mem_addr = 8'(8'h40 + k); bus.mem_wdata = 32'h2000 + 32'(k);
            bus.wb_en = 1'b1; bus.wb_ctrl = 1'b1;
            bus.wb_addr = 6'(10 + k); bus.wb_data = 32'h3000 + 32'(k);
            bus.rf_raddr = 6'(10 + k);
            tick();
            check_eq($sformatf("conc_fdone_%0d", k), {31'd0, bus.fetch_done}, 32'h1);
            check_eq($sformatf("conc_mdone_%0d", k), {31'd0, bus.mem_done}, 32'h1);
            check_eq($sformatf("conc_wdone_%0d", k), {31'd0, bus.wb_done}, 32'h1);
            check_eq($sformatf("conc_instr_%0d", k), bus.cur_instr, 32'h1004 + 32'(k));
            check_eq($sformatf("conc_rf_%0d", k), bus.rf_rdata, 32'h3000 + 32'(k));
        end
        idle();
        tick();
        check_eq("conc_fdone_end", {31'd0, bus.fetch_done}, 32'h0);
        check_eq("conc_mdone_end", {31'd0, bus.mem_done}, 32'h0);
        check_eq("conc_wdone_end", {31'd0, bus.wb_done}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            bus.mem_en = 1'b1; bus.mem_read = 1'b1; bus.mem_addr = 8'(8'h40 + k);
            tick();
            check_eq($sformatf("conc_mem_%0d", k), bus.mem_rdata, 32'h2000 + 32'(k));
        end
        idle();

        // Second reset: memories retained, registers cleared, writes blocked.
        bus.mem_en = 1'b1; bus.mem_write = 1'b1; bus.mem_addr = 8'h20; bus.mem_wdata = 32'h1111_1111;
        tick();
        start = 1'b1;
        bus.mem_wdata = 32'hFFFF_0000;
        bus.wb_en = 1'b1; bus.wb_ctrl = 1'b1; bus.wb_addr = 6'd7; bus.wb_data = 32'hFFFF_FFFF;
        bus.rf_raddr = 6'd7;
        bus.fetch_en = 1'b1;
        tick();
        start = 1'b0;
        idle();
        check_eq("rst2_rf7", bus.rf_rdata, 32'h0);
        check_eq("rst2_cur_instr", bus.cur_instr, 32'h0);
        check_eq("rst2_mem_rdata", bus.mem_rdata, 32'h0);
        bus.mem_en = 1'b1; bus.mem_read = 1'b1; bus.mem_addr = 8'h20;
        bus.fetch_en = 1'b1; bus.pc = 4'd3;
        tick();
        idle();
        check_eq("rst2_dmem_kept", bus.mem_rdata, 32'h1111_1111);
        check_eq("rst2_imem_kept", bus.cur_instr, 32'h0000_0011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
